xbar_config_loader: RTL and testbench

//  Writes the per-output select fields that the LUT-tile crossbar reads on io_mux_configs.

---
 rtl/xbar_config_loader.sv | 124 ++++++++++++
 tb/tb_xbar_config_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_config_loader.sv
// xbar_config_loader
//   Loads the crossbar select fields from a WORD_W-bit valid/ready bitstream.
//   The words are assembled LSB-first into a shadow register. After the last
//   word, every select field is range-checked. The whole set is then committed
//   to io_mux_configs in one cycle, or rejected with io_cfg_err set.
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   io_start            1-cycle pulse, begins a load (honoured only in IDLE)
//   io_abort            drops the load in progress (LOAD/CHECK), no commit
//   io_in_valid/data    bitstream word stream
//   io_in_ready         high while in LOAD
//   io_busy             high whenever not IDLE
//   io_done             1-cycle pulse on a successful commit
//   io_cfg_err          sticky, last load rejected; cleared by the next io_start
//   io_mux_configs      active config, field i = [i*SEL_BITS +: SEL_BITS]
// SEL_BITS must satisfy 2**SEL_BITS >= NUM_INS.
module xbar_config_loader #(
  parameter int unsigned NUM_INS  = 18,
  parameter int unsigned NUM_OUTS = 20,
  parameter int unsigned SEL_BITS = 5,
  parameter int unsigned WORD_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         io_start,
  input  logic                         io_abort,
  input  logic                         io_in_valid,
  input  logic [WORD_W-1:0]            io_in_data,
  output logic                         io_in_ready,
  output logic                         io_busy,
  output logic                         io_done,
  output logic                         io_cfg_err,
  output logic [NUM_OUTS*SEL_BITS-1:0] io_mux_configs
);

  localparam int unsigned CFG_W     = NUM_OUTS * SEL_BITS;
  localparam int unsigned NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;
  localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             field_bad;

  // Any select field pointing past the last crossbar input rejects the load.
  always_comb begin
    field_bad = 1'b0;
    for (int unsigned i = 0; i < NUM_OUTS; i++) begin
      if (32'(shadow_q[i*SEL_BITS +: SEL_BITS]) >= NUM_INS) field_bad = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (io_start) begin
          state_d  = LOAD;
          count_d  = '0;
          shadow_d = '0;
          err_d    = 1'b0;
        end
      end
      LOAD: begin
        if (io_abort) begin
          state_d = IDLE;
        end else if (io_in_valid) begin
          // Shadow is cleared at start, so OR-ing the shifted word writes the
          // slot; the shift naturally drops bits of the last word beyond CFG_W.
          shadow_d = shadow_q | (CFG_W'(io_in_data) << (count_q * WORD_W));
          count_d  = count_q + 1'b1;
          if (count_q == CNT_W'(NUM_WORDS - 1)) state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!io_abort) begin
          if (field_bad) begin
            err_d = 1'b1;
          end else begin
            cfg_d  = shadow_q;
            done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign io_in_ready    = (state_q == LOAD);
  assign io_busy        = (state_q != IDLE);
  assign io_done        = done_q;
  assign io_cfg_err     = err_q;
  assign io_mux_configs = cfg_q;

endmodule

// File: tb/tb_xbar_config_loader.sv
module tb_xbar_config_loader;
  localparam int unsigned NUM_INS   = 18;
  localparam int unsigned NUM_OUTS  = 20;
  localparam int unsigned SEL_BITS  = 5;
  localparam int unsigned WORD_W    = 8;
  localparam int unsigned CFG_W     = 100;
  localparam int unsigned NUM_WORDS = 13;

  logic              clk = 1'b0;
  logic              reset;
  logic              io_start, io_abort, io_in_valid;
  logic [WORD_W-1:0] io_in_data;
  logic              io_in_ready, io_busy, io_done, io_cfg_err;
  logic [CFG_W-1:0]  io_mux_configs;

  always #5 clk = ~clk;

  xbar_config_loader #(
    .NUM_INS (NUM_INS),
    .NUM_OUTS(NUM_OUTS),
    .SEL_BITS(SEL_BITS),
    .WORD_W  (WORD_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (io_start),
    .io_abort      (io_abort),
    .io_in_valid   (io_in_valid),
    .io_in_data    (io_in_data),
    .io_in_ready   (io_in_ready),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_cfg_err    (io_cfg_err),
    .io_mux_configs(io_mux_configs)
  );

  typedef struct {
    bit               err;
    logic [CFG_W-1:0] cfg;
  } exp_t;

  exp_t             sbq[$];
  int               errors = 0;
  int               checks = 0;
  logic [CFG_W-1:0] active_m = '0;
  logic             err_prev = 1'b0;
  int               fld[NUM_OUTS];

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: configuration is simply the select values laid side by side.
  function automatic logic [CFG_W-1:0] pack_fields();
    logic [CFG_W-1:0] c = '0;
    for (int i = 0; i < NUM_OUTS; i++) c = c | (CFG_W'(fld[i]) << (i * SEL_BITS));
    return c;
  endfunction

  // Monitor: pops expectations whenever the DUT reports a commit or a rejection.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      active_m = '0;
      err_prev = 1'b0;
      sbq.delete();
    end else begin
      if (io_done) begin
        if (sbq.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_done: got io_done=1 expected no commit at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("done_on_good_load", e.err, 1'b0);
          chkv("commit_cfg", io_mux_configs, e.cfg);
          active_m = e.cfg;
        end
      end else begin
        chkv("cfg_stable", io_mux_configs, active_m);
      end
      if (io_cfg_err && !err_prev) begin
        if (sbq.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_cfg_err: got io_cfg_err=1 expected 0 at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("err_on_bad_load", e.err, 1'b1);
        end
      end
      err_prev = io_cfg_err;
    end
  end

  // Called and returns #1 after a rising edge.
  // gap_mode: 0 back-to-back, 1 pattern 1,0,0, 2 random. abort_after<0: no abort.
  task automatic run_load(input logic [CFG_W-1:0] cfg, input logic [3:0] junk,
                          input int gap_mode, input int abort_after);
    logic [NUM_WORDS*WORD_W-1:0] stream;
    logic [CFG_W-1:0]            f;
    bit                          bad = 0;
    bit                          v;
    int                          accepted = 0;
    int                          cyc = 0;
    stream = {junk, cfg};
    for (int i = 0; i < NUM_OUTS; i++) begin
      f = (cfg >> (i * SEL_BITS)) & CFG_W'(31);
      if (f >= CFG_W'(NUM_INS)) bad = 1;
    end
    if (abort_after < 0) sbq.push_back('{bad, cfg});
    io_start = 1'b1;
    @(posedge clk); #1;
    io_start = 1'b0;
    chk("busy_after_start", io_busy, 1'b1);
    chk("cfg_err_cleared_on_start", io_cfg_err, 1'b0);
    while (accepted < NUM_WORDS) begin
      if (cyc > 300) begin
        errors++;
        checks++;
        $display("FAIL load_timeout: got %0d words expected %0d", accepted, NUM_WORDS);
        io_in_valid = 1'b0;
        return;
      end
      if (abort_after >= 0 && accepted == abort_after) begin
        io_abort    = 1'b1;
        io_in_valid = 1'b1;
        io_in_data  = stream[accepted*WORD_W +: WORD_W];
        @(posedge clk); #1;
        io_abort    = 1'b0;
        io_in_valid = 1'b0;
        chk("abort_busy", io_busy, 1'b0);
        chk("abort_ready", io_in_ready, 1'b0);
        @(posedge clk); #1;
        chk("abort_no_done", io_done, 1'b0);
        return;
      end
      case (gap_mode)
        0:       v = 1;
        1:       v = (cyc % 3 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      io_in_valid = v;
      io_in_data  = v ? stream[accepted*WORD_W +: WORD_W] : WORD_W'($urandom);
      @(negedge clk);
      chk("ready_in_load", io_in_ready, 1'b1);
      @(posedge clk); #1;
      if (v) accepted++;
      cyc++;
    end
    io_in_valid = 1'b0;
    chk("check_ready_low", io_in_ready, 1'b0);
    chk("check_busy", io_busy, 1'b1);
    @(posedge clk); #1;
    chk("done_latency", io_done, !bad);
    chk("idle_after_check", io_busy, 1'b0);
    chk("cfg_err_value", io_cfg_err, bad);
    @(posedge clk); #1;
    chk("done_falls", io_done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0]      xin;
    logic [CFG_W-1:0] c, got, exp;
    logic [4:0]       sel;
    reset = 1'b1; io_start = 1'b0; io_abort = 1'b0; io_in_valid = 1'b0; io_in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chkv("reset_cfg", io_mux_configs, '0);
    chk("reset_busy", io_busy, 1'b0);
    chk("reset_ready", io_in_ready, 1'b0);
    chk("reset_done", io_done, 1'b0);
    chk("reset_err", io_cfg_err, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Field i = i mod 18, back-to-back
    for (int i = 0; i < NUM_OUTS; i++) fld[i] = i % NUM_INS;
    c = pack_fields();
    run_load(c, 4'h0, 0, -1);
    chkv("field1", CFG_W'(io_mux_configs[9:5]), CFG_W'(1));
    chkv("field18", CFG_W'(io_mux_configs[94:90]), CFG_W'(0));
    chkv("field19", CFG_W'(io_mux_configs[99:95]), CFG_W'(1));
    xin = 18'h2AAAA;
    got = '0;
    exp = '0;
    for (int i = 0; i < NUM_OUTS; i++) begin
      sel = io_mux_configs[i*SEL_BITS +: SEL_BITS];
      got[i] = (sel < 5'd18) ? xin[sel] : 1'bx;
      exp[i] = xin[i % NUM_INS];
    end
    chkv("xbar_route", got, exp);

    // Reset in the middle of a load
    io_start = 1'b1;
    @(posedge clk); #1;
    io_start = 1'b0;
    io_in_valid = 1'b1;
    io_in_data = 8'hA5;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chkv("midrun_reset_cfg", io_mux_configs, '0);
    chk("midrun_reset_busy", io_busy, 1'b0);
    chk("midrun_reset_ready", io_in_ready, 1'b0);
    chk("midrun_reset_done", io_done, 1'b0);
    chk("midrun_reset_err", io_cfg_err, 1'b0);
    io_in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Same load with gaps
    run_load(c, 4'h0, 1, -1);
    // Junk above CFG_W in the last word
    run_load(c, 4'hF, 0, -1);
    // Out-of-range field 7 after a good load
    fld[7] = 18;
    run_load(pack_fields(), 4'h0, 0, -1);
    chkv("err_keeps_cfg", io_mux_configs, c);
    // Abort after 6 words, then a fresh load (its start clears io_cfg_err)
    fld[7] = 7;
    fld[0] = 17;
    run_load(pack_fields(), 4'h3, 0, 6);
    chkv("abort_keeps_cfg", io_mux_configs, c);
    run_load(pack_fields(), 4'h3, 0, -1);
    chkv("post_abort_cfg", io_mux_configs, pack_fields());

    // Randomized loads, some with a bad field
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < NUM_OUTS; i++) fld[i] = $urandom_range(0, NUM_INS - 1);
      if ($urandom_range(0, 2) == 0) fld[$urandom_range(0, NUM_OUTS - 1)] = $urandom_range(NUM_INS, 31);
      run_load(pack_fields(), 4'($urandom), 2, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 12)) : -1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size() == 0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
